// File: rtl/pll_phase_step_ctrl.sv
// pll_phase_step_ctrl: sequences EHXPLLL dynamic phase steps and filters/monitors PLL lock
//   clock, reset_n            25 MHz reference clock, async active-low reset
//   pll_locked                raw asynchronous PLL LOCK
//   req_*                     one request: channel sel, direction, step count (0 = no-op)
//   phase*                    PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG (strobes idle high)
//   lock_ok, lock_drops       filtered lock and saturating count of its falls
//   busy, done, err, err_sticky  sequencer status
module pll_phase_step_ctrl #(
  parameter int SETUP_CYCLES = 2,
  parameter int STEP_WIDTH   = 2,
  parameter int STEP_GAP     = 4,
  parameter int LOCK_FILTER  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       lock_ok,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       err_sticky,
  output logic [7:0] lock_drops
);
  localparam int MAXC = (LOCK_TIMEOUT > SETUP_CYCLES + STEP_WIDTH + STEP_GAP) ? LOCK_TIMEOUT : SETUP_CYCLES + STEP_WIDTH + STEP_GAP;
  localparam int CW = $clog2(MAXC + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  typedef enum logic [2:0] {IDLE, SETUP, STEP_LO, STEP_HI, LOAD, WAIT_LOCK, DONE, ERR} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [FW-1:0] fcnt;
  logic [CW-1:0] cnt;
  logic [7:0] rem;
  logic accept;
  assign req_ready = (state == IDLE) && lock_ok;
  assign accept = req_valid && req_ready;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync       <= '0;
      fcnt       <= '0;
      lock_ok    <= 1'b0;
      lock_drops <= '0;
    end else begin
      sync <= {sync[0], pll_locked};
      if (!sync[1]) begin
        fcnt    <= '0;
        lock_ok <= 1'b0;
        if (lock_ok && lock_drops != 8'hff) lock_drops <= lock_drops + 1'b1;
      end else if (fcnt == FW'(LOCK_FILTER - 1)) lock_ok <= 1'b1;
      else fcnt <= fcnt + 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (accept) state_n = (req_steps == 8'd0) ? DONE : SETUP;
      SETUP:     if (cnt == CW'(SETUP_CYCLES - 1)) state_n = STEP_LO;
      STEP_LO:   if (cnt == CW'(STEP_WIDTH - 1)) state_n = STEP_HI;
      STEP_HI:   if (cnt == CW'(STEP_GAP - 1)) state_n = (rem == 8'd1) ? LOAD : STEP_LO;
      LOAD:      if (cnt == CW'(STEP_WIDTH - 1)) state_n = WAIT_LOCK;
      WAIT_LOCK: state_n = lock_ok ? DONE : (cnt == CW'(LOCK_TIMEOUT - 1)) ? ERR : WAIT_LOCK;
      default:   state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      phasesel     <= '0;
      phasedir     <= 1'b0;
      phasestep    <= 1'b1;
      phaseloadreg <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        rem        <= req_steps;
        err_sticky <= 1'b0;
        if (req_steps != 8'd0) begin
          phasesel <= req_sel;
          phasedir <= req_dir;
        end
      end else if (state == STEP_HI && state_n != STEP_HI) rem <= rem - 1'b1;
      if (state_n == ERR) err_sticky <= 1'b1;
      phasestep    <= state_n != STEP_LO;
      phaseloadreg <= state_n != LOAD;
      busy         <= state_n != IDLE;
      done         <= state_n == DONE;
      err          <= state_n == ERR;
    end
  end
endmodule
